main_ctrl_fsm: RTL and testbench



---
 rtl/main_ctrl_fsm_pkg.sv | 39 +++
 rtl/main_ctrl_fsm_if.sv | 38 +++
 rtl/main_ctrl_fsm_out_decode.sv | 108 ++++++++++
 rtl/main_ctrl_fsm.sv | 94 +++++++++
 tb/tb_main_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/main_ctrl_fsm_pkg.sv
// rtl/main_ctrl_fsm_pkg.sv - shared encodings for the multi-cycle main control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// rtl/main_ctrl_fsm_if.sv - control-unit to datapath signal bundle
interface main_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_ct_op;
  logic [1:0]       pc_source;
  logic [3:0]       state_o;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  // Control unit side: reads the instruction opcode and memory handshake.
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ct_op,
           pc_source, state_o, instr_done, illegal_op, instr_count
  );

  // Datapath side: supplies the opcode and memory handshake.
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ct_op,
           pc_source, state_o, instr_done, illegal_op, instr_count
  );
endinterface

// File: rtl/main_ctrl_fsm_out_decode.sv
// rtl/main_ctrl_fsm_out_decode.sv - Moore output decode for the main control FSM
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       rst,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ct_op,
  output logic [1:0] pc_source,
  output logic       instr_done
);

  // State-driven controls; memory-state enables gated by mem_ready, all enables killed in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_ct_op     = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE:   alu_src_b = SRCB_IMM_SH2;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = mem_ready;
        instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ct_op = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ct_op     = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// rtl/main_ctrl_fsm.sv - multi-cycle main control unit with retired-instruction counter
module main_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit WAIT_MEM = 1'b1
) (
  input logic            clk,
  input logic            rst,
  main_ctrl_fsm_if.master bus
);

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] count_q;
  logic             ready;
  logic             done;
  logic             illegal;

  assign ready = WAIT_MEM ? bus.mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Opcode is captured in DECODE so MEM_ADDR ignores later IR changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    op_q <= '0;
    else if (state == ST_DECODE) op_q <= bus.opcode;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count_q <= '0;
    else if (done) count_q <= count_q + CNT_W'(1);
  end

  // Next-state logic and illegal-opcode detection in DECODE.
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    case (state)
      ST_FETCH: if (ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_nxt = ST_R_EXEC;
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
          OP_ADDIU:     state_nxt = ST_I_EXEC;
          default: begin
            state_nxt = ST_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: state_nxt = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (ready) state_nxt = ST_MEM_WB;
      ST_MEM_WR:   if (ready) state_nxt = ST_FETCH;
      ST_R_EXEC:   state_nxt = ST_R_WB;
      ST_I_EXEC:   state_nxt = ST_I_WB;
      default:     state_nxt = ST_FETCH;
    endcase
  end

  ctrl_out_decode u_decode (
    .state         (state),
    .mem_ready     (ready),
    .rst           (rst),
    .pc_write      (bus.pc_write),
    .pc_write_cond (bus.pc_write_cond),
    .i_or_d        (bus.i_or_d),
    .mem_read      (bus.mem_read),
    .mem_write     (bus.mem_write),
    .ir_write      (bus.ir_write),
    .mem_to_reg    (bus.mem_to_reg),
    .reg_dst       (bus.reg_dst),
    .reg_write     (bus.reg_write),
    .alu_src_a     (bus.alu_src_a),
    .alu_src_b     (bus.alu_src_b),
    .alu_ct_op     (bus.alu_ct_op),
    .pc_source     (bus.pc_source),
    .instr_done    (done)
  );

  assign bus.instr_done  = done;
  assign bus.illegal_op  = illegal & ~rst;
  assign bus.state_o     = state;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb/tb_main_ctrl_fsm.sv - self-checking bench for main_ctrl_fsm
module tb_main_ctrl_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  main_ctrl_fsm_if #(.CNT_W(32)) bus ();

  main_ctrl_fsm #(.CNT_W(32), .WAIT_MEM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op}
  logic [11:0] en;
  assign en = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
               bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
               bus.instr_done, bus.illegal_op};

  localparam logic [11:0] E_F1   = 12'b1001_0100_0000;
  localparam logic [11:0] E_F0   = 12'b0001_0000_0000;
  localparam logic [11:0] E_NONE = 12'b0000_0000_0000;
  localparam logic [11:0] E_ILL  = 12'b0000_0000_0001;
  localparam logic [11:0] E_SRCA = 12'b0000_0000_0100;
  localparam logic [11:0] E_RWB  = 12'b0000_0001_1010;
  localparam logic [11:0] E_MRD  = 12'b0011_0000_0000;
  localparam logic [11:0] E_MWB  = 12'b0000_0010_1010;
  localparam logic [11:0] E_MWR1 = 12'b0010_1000_0010;
  localparam logic [11:0] E_MWR0 = 12'b0010_0000_0000;
  localparam logic [11:0] E_BR   = 12'b0100_0000_0110;
  localparam logic [11:0] E_JMP  = 12'b1000_0000_0010;
  localparam logic [11:0] E_IWB  = 12'b0000_0000_1010;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [11:0] en;
    logic [1:0]  srcb;
    logic [1:0]  aluop;
    logic [1:0]  pcs;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic [5:0] op, input logic [3:0] st,
                     input logic [11:0] e, input logic [1:0] srcb, input logic [1:0] aluop,
                     input logic [1:0] pcs, input int cnt);
    vec_t v;
    v.rdy = rdy; v.op = op; v.st = st; v.en = e;
    v.srcb = srcb; v.aluop = aluop; v.pcs = pcs; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: each instruction class is a fixed walk of state numbers;
  // FETCH, MEM_RD and MEM_WR repeat while mem_ready is low.
  int path[5];
  int plen;
  bit legal;

  task automatic set_path(input logic [5:0] op);
    legal = 1'b1;
    path[0] = 0; path[1] = 1;
    case (op)
      6'h00: begin path[2] = 6;  path[3] = 7;  plen = 4; end
      6'h23: begin path[2] = 2;  path[3] = 3;  path[4] = 4; plen = 5; end
      6'h2B: begin path[2] = 2;  path[3] = 5;  plen = 4; end
      6'h04: begin path[2] = 8;  plen = 3; end
      6'h02: begin path[2] = 9;  plen = 3; end
      6'h09: begin path[2] = 10; path[3] = 11; plen = 4; end
      default: begin plen = 2; legal = 1'b0; end
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h09;
  endfunction

  logic [5:0] op;
  logic       rdy;
  int         model_cnt;
  int         idx;
  int         exp_st;
  bit         exp_done;
  bit         stall;

  initial begin
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;

    // Reset state: FETCH mux values, all enables low, counter clear.
    @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(bus.state_o), 0);
    chk("reset_en", 32'(en), 32'(E_NONE));
    chk("reset_srcb", 32'(bus.alu_src_b), 1);
    chk("reset_count", bus.instr_count, 0);

    // Directed sequence: R, lw (stalls), sw (stall), beq, j, addiu, illegal.
    add(1, 6'h00, 0,  E_F1,   2'b01, 2'b00, 2'b00, 0);
    add(1, 6'h00, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 0);
    add(1, 6'h00, 6,  E_SRCA, 2'b00, 2'b10, 2'b00, 0);
    add(1, 6'h00, 7,  E_RWB,  2'b00, 2'b00, 2'b00, 0);
    add(0, 6'h23, 0,  E_F0,   2'b01, 2'b00, 2'b00, 1);
    add(1, 6'h23, 0,  E_F1,   2'b01, 2'b00, 2'b00, 1);
    add(1, 6'h23, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 1);
    add(1, 6'h2B, 2,  E_SRCA, 2'b10, 2'b00, 2'b00, 1);
    add(0, 6'h00, 3,  E_MRD,  2'b00, 2'b00, 2'b00, 1);
    add(0, 6'h00, 3,  E_MRD,  2'b00, 2'b00, 2'b00, 1);
    add(1, 6'h00, 3,  E_MRD,  2'b00, 2'b00, 2'b00, 1);
    add(1, 6'h00, 4,  E_MWB,  2'b00, 2'b00, 2'b00, 1);
    add(1, 6'h2B, 0,  E_F1,   2'b01, 2'b00, 2'b00, 2);
    add(1, 6'h2B, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 2);
    add(1, 6'h23, 2,  E_SRCA, 2'b10, 2'b00, 2'b00, 2);
    add(0, 6'h23, 5,  E_MWR0, 2'b00, 2'b00, 2'b00, 2);
    add(1, 6'h23, 5,  E_MWR1, 2'b00, 2'b00, 2'b00, 2);
    add(1, 6'h04, 0,  E_F1,   2'b01, 2'b00, 2'b00, 3);
    add(1, 6'h04, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 3);
    add(1, 6'h04, 8,  E_BR,   2'b00, 2'b01, 2'b01, 3);
    add(1, 6'h02, 0,  E_F1,   2'b01, 2'b00, 2'b00, 4);
    add(1, 6'h02, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 4);
    add(1, 6'h02, 9,  E_JMP,  2'b00, 2'b00, 2'b10, 4);
    add(1, 6'h09, 0,  E_F1,   2'b01, 2'b00, 2'b00, 5);
    add(1, 6'h09, 1,  E_NONE, 2'b11, 2'b00, 2'b00, 5);
    add(1, 6'h09, 10, E_SRCA, 2'b10, 2'b00, 2'b00, 5);
    add(1, 6'h09, 11, E_IWB,  2'b00, 2'b00, 2'b00, 5);
    add(1, 6'h3F, 0,  E_F1,   2'b01, 2'b00, 2'b00, 6);
    add(1, 6'h3F, 1,  E_ILL,  2'b11, 2'b00, 2'b00, 6);
    add(1, 6'h00, 0,  E_F1,   2'b01, 2'b00, 2'b00, 6);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.mem_ready = tbl[i].rdy;
      bus.opcode = tbl[i].op;
      @(negedge clk);
      chk($sformatf("row%0d_state", i), 32'(bus.state_o), 32'(tbl[i].st));
      chk($sformatf("row%0d_en", i), 32'(en), 32'(tbl[i].en));
      chk($sformatf("row%0d_srcb", i), 32'(bus.alu_src_b), 32'(tbl[i].srcb));
      chk($sformatf("row%0d_aluop", i), 32'(bus.alu_ct_op), 32'(tbl[i].aluop));
      chk($sformatf("row%0d_pcsrc", i), 32'(bus.pc_source), 32'(tbl[i].pcs));
      chk($sformatf("row%0d_count", i), bus.instr_count, tbl[i].cnt);
      @(posedge clk); #1;
    end

    // Reset asserted during MEM_WB of lw after one retired R-type.
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.opcode = 6'h23;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_state", 32'(bus.state_o), 4);
    chk("abort_pre_count", bus.instr_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_state", 32'(bus.state_o), 0);
    chk("abort_en", 32'(en), 32'(E_NONE));
    chk("abort_srcb", 32'(bus.alu_src_b), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_after_count", bus.instr_count, 0);
    chk("abort_after_state", 32'(bus.state_o), 0);
    @(posedge clk); #1;

    // Randomized instruction stream against the path model.
    model_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        5: op = 6'h09;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      set_path(op);
      idx = 0;
      while (idx < plen) begin
        exp_st = path[idx];
        rdy = ($urandom_range(0, 9) < 7);
        bus.mem_ready = rdy;
        bus.opcode = (exp_st <= 1) ? op : 6'($urandom);
        @(negedge clk);
        stall = (exp_st == 0 || exp_st == 3 || exp_st == 5) && !rdy;
        exp_done = legal && (idx == plen - 1) && !(exp_st == 5 && !rdy);
        chk($sformatf("rnd%0d_state", n), 32'(bus.state_o), 32'(exp_st));
        chk($sformatf("rnd%0d_done", n), 32'(bus.instr_done), 32'(exp_done));
        chk($sformatf("rnd%0d_illegal", n), 32'(bus.illegal_op), 32'(!legal && exp_st == 1));
        chk($sformatf("rnd%0d_count", n), bus.instr_count, model_cnt);
        chk($sformatf("rnd%0d_mem_read", n), 32'(bus.mem_read), 32'(exp_st == 0 || exp_st == 3));
        chk($sformatf("rnd%0d_mem_write", n), 32'(bus.mem_write), 32'(exp_st == 5 && rdy));
        chk($sformatf("rnd%0d_reg_write", n), 32'(bus.reg_write),
            32'(exp_st == 4 || exp_st == 7 || exp_st == 11));
        if (exp_done) model_cnt++;
        if (!stall) idx++;
        @(posedge clk); #1;
      end
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rnd_final_count", bus.instr_count, model_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
